prio_extint_controller: RTL

PRIO_EXTINT_CONTROLLER -- requirements
Module: prio_extint_controller

---
 rtl/prio_extint_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/prio_extint_controller.sv
// Prioritised external interrupt controller: synchronised edge/level sources with
// PEND/ENABLE/MODE/CLAIM word registers on a simple request/response bus.

module prio_extint_controller #(
  parameter int unsigned              SRC_NUM       = 8,
  parameter int unsigned              SYNC_STAGES   = 2,
  parameter int unsigned              VA_WIDTH      = 4,
  parameter int unsigned              BUS_WIDTH     = 32,
  parameter int unsigned              BUS_ACC_WIDTH = 2,
  parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B    = BUS_ACC_WIDTH'(2)
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     ext_int_trigger,
  input  logic                     ext_int_handled,
  input  logic [SRC_NUM-1:0]       ext_int_from,
  input  logic [VA_WIDTH-1:0]      addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic                     resp,
  output logic                     fault
);

  localparam int unsigned CLAIM_W  = $clog2(SRC_NUM + 1);
  localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

  localparam logic [VA_WIDTH-1:0] A_PEND  = VA_WIDTH'(0);
  localparam logic [VA_WIDTH-1:0] A_EN    = VA_WIDTH'(4);
  localparam logic [VA_WIDTH-1:0] A_MODE  = VA_WIDTH'(8);
  localparam logic [VA_WIDTH-1:0] A_CLAIM = VA_WIDTH'(12);

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  logic [SRC_NUM-1:0]   line_sync;
  logic [SRC_NUM-1:0]   pend_q, pend_d, enable_q, enable_d, mode_q, mode_d, prev_q;
  logic [SRC_NUM-1:0]   masked, win_oh, clr, edge_det;
  logic [CLAIM_W-1:0]   win_id;
  logic [WARM_W-1:0]    warm_q, warm_d;
  logic                 armed, addr_ok, invalid, acc_ok, claim_rd;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d, rd_val;
  logic                 resp_q, resp_d;
  logic                 unused_wdata;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= '0;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  if (SYNC_STAGES == 0) begin : g_nosync
    assign line_sync = ext_int_from;
  end else begin : g_sync
    logic [SRC_NUM-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= ext_int_from;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign line_sync = sync_q[SYNC_STAGES-1];
  end

  assign masked          = pend_q & enable_q;
  assign ext_int_trigger = |masked;
  assign armed           = (warm_q == WARM_W'(WARM_MAX));
  assign fault           = req & invalid;
  assign unused_wdata    = ^wdata;

  // Bus decode, claim arbitration and pending-bit update.
  always_comb begin
    addr_ok  = (addr == A_PEND) || (addr == A_EN) || (addr == A_MODE) || (addr == A_CLAIM);
    invalid  = (acc != BUS_ACC_4B) || !addr_ok || (w_rb && (addr == A_CLAIM));
    acc_ok   = req && !invalid;
    claim_rd = acc_ok && !w_rb && (addr == A_CLAIM);
    win_oh   = masked & (~masked + SRC_NUM'(1));
    win_id   = '0;
    for (int i = int'(SRC_NUM) - 1; i >= 0; i--) begin
      if (masked[i]) win_id = CLAIM_W'(i + 1);
    end

    clr = '0;
    if (acc_ok && w_rb && (addr == A_PEND)) clr = clr | wdata[SRC_NUM-1:0];
    if (claim_rd || ext_int_handled)        clr = clr | win_oh;

    // Lines already high when reset released must not look like fresh edges.
    edge_det = armed ? (line_sync & ~prev_q) : '0;
    warm_d   = armed ? warm_q : warm_q + WARM_W'(1);
    pend_d   = (mode_q & line_sync) | (~mode_q & (edge_det | (pend_q & ~clr)));

    enable_d = enable_q;
    mode_d   = mode_q;
    if (acc_ok && w_rb && (addr == A_EN))   enable_d = wdata[SRC_NUM-1:0];
    if (acc_ok && w_rb && (addr == A_MODE)) mode_d   = wdata[SRC_NUM-1:0];

    case (addr)
      A_PEND:  rd_val = BUS_WIDTH'(pend_q);
      A_EN:    rd_val = BUS_WIDTH'(enable_q);
      A_MODE:  rd_val = BUS_WIDTH'(mode_q);
      A_CLAIM: rd_val = BUS_WIDTH'(win_id);
      default: rd_val = '0;
    endcase
    rdata_d = (acc_ok && !w_rb) ? rd_val : rdata_q;
    resp_d  = acc_ok;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pend_q   <= '0;
      enable_q <= '1;
      mode_q   <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      prev_q   <= line_sync;
      warm_q   <= warm_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;

endmodule
